// File: rtl/mul_grs_normalizer_if.sv
// Handshake and data bundle between the multiplier front end, the GRS normaliser
// and the downstream rounding stage.
// The slave modport is the normaliser's view. The master modport is its environment:
// the product source plus the rounding-stage sink.
interface mul_grs_normalizer_if #(
  parameter int unsigned W_EXP = 10
) ();

  // Upstream: raw product in
  logic                    in_valid;
  logic                    in_ready;
  logic [47:0]             prod;
  logic signed [W_EXP-1:0] exp_in;
  logic                    sign_in;

  // Downstream: normalised fraction plus guard/round/sticky out
  logic                    out_valid;
  logic                    out_ready;
  logic [25:0]             mul_normalize;
  logic signed [W_EXP-1:0] exp_out;
  logic                    sign_out;
  logic                    zero_out;
  logic                    ovf_out;
  logic                    uflow_out;

  modport slave (
    input  in_valid, prod, exp_in, sign_in, out_ready,
    output in_ready, out_valid, mul_normalize, exp_out, sign_out, zero_out, ovf_out,
           uflow_out
  );

  modport master (
    output in_valid, prod, exp_in, sign_in, out_ready,
    input  in_ready, out_valid, mul_normalize, exp_out, sign_out, zero_out, ovf_out,
           uflow_out
  );

endinterface

// File: rtl/mul_grs_normalizer.sv
// Normalises a raw 24x24 mantissa product so the hidden one lands at bit 46.
// It adjusts the exponent to match and produces {frac[22:0], guard, round, sticky}
// for the rounding stage.
// Products with the top bit at 46 or 47 finish in one cycle. Smaller products, which
// come from denormal operands, are shifted left one bit per enabled cycle.
module mul_grs_normalizer #(
  parameter int unsigned W_EXP   = 10,
  parameter int          EXP_MIN = -126,
  parameter int          EXP_MAX = 127
) (
  input logic                 clk,
  input logic                 arst_n,
  input logic                 en,
  mul_grs_normalizer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic signed [W_EXP-1:0] ExpMinW = W_EXP'(EXP_MIN);
  localparam logic signed [W_EXP-1:0] ExpMaxW = W_EXP'(EXP_MAX);
  localparam logic signed [W_EXP-1:0] ExpOne  = W_EXP'(1);

  state_e                  state_q;
  // R[45:0] only. The hidden bit is always 1 at DONE, or the whole product is zero
  // and zero_q is set, so it is never stored.
  logic [45:0]             r_q;
  logic signed [W_EXP-1:0] exp_q;
  logic                    sign_q;
  logic                    lost_q;  // bit dropped by the right shift on the bit-47 path
  logic                    zero_q;

  // Control FSM plus datapath registers. en low freezes everything.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= StIdle;
      r_q     <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      lost_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else if (en) begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            r_q    <= bus.prod[45:0];
            exp_q  <= bus.exp_in;
            sign_q <= bus.sign_in;
            lost_q <= 1'b0;
            zero_q <= 1'b0;
            if (bus.prod == 48'd0) begin
              zero_q  <= 1'b1;
              exp_q   <= '0;
              state_q <= StDone;
            end else if (bus.prod[47]) begin
              r_q     <= bus.prod[46:1];
              lost_q  <= bus.prod[0];
              exp_q   <= bus.exp_in + ExpOne;
              state_q <= StDone;
            end else if (bus.prod[46]) begin
              state_q <= StDone;
            end else begin
              state_q <= StShift;
            end
          end
        end
        StShift: begin
          r_q   <= {r_q[44:0], 1'b0};
          exp_q <= exp_q - ExpOne;
          // R[45] moves up into the hidden position with this shift.
          if (r_q[45]) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Output decode from the held registers. All of it stays stable while DONE.
  always_comb begin
    bus.in_ready      = (state_q == StIdle) & en;
    bus.out_valid     = (state_q == StDone);
    bus.mul_normalize = {r_q[45:23], r_q[22], r_q[21], (|r_q[20:0]) | lost_q};
    bus.exp_out       = exp_q;
    bus.sign_out      = sign_q;
    bus.zero_out      = zero_q;
    bus.ovf_out       = (exp_q > ExpMaxW);
    bus.uflow_out     = (exp_q < ExpMinW) & ~zero_q;
  end

endmodule

// File: tb/tb_mul_grs_normalizer.sv
// Bench for mul_grs_normalizer: directed corner products, then random products of
// mantissas with random leading-zero counts. Each result is compared with a
// leading-one-search reference model.
module tb_mul_grs_normalizer;

  logic clk = 1'b0;
  logic arst_n;
  logic en;

  int n_vec = 0;
  int n_err = 0;

  mul_grs_normalizer_if #(.W_EXP(10)) bus ();

  mul_grs_normalizer #(
    .W_EXP  (10),
    .EXP_MIN(-126),
    .EXP_MAX(127)
  ) dut (
    .clk   (clk),
    .arst_n(arst_n),
    .en    (en),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [25:0]       mn;
    logic signed [9:0] ex;
    logic              zero;
    logic              ovf;
    logic              uflow;
    int                n;
  } exp_t;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // Reference: find the leading one, scale it to bit 46, then slice out G/R/S.
  function automatic exp_t model(input logic [47:0] p, input int e);
    exp_t        r;
    int          msb;
    int          ex;
    logic [47:0] q;
    msb = -1;
    for (int i = 0; i < 48; i++) if (p[i]) msb = i;
    r.zero = (msb < 0);
    r.n    = 0;
    if (msb < 0) begin
      r.mn = '0;
      ex   = 0;
    end else if (msb == 47) begin
      r.mn = {p[46:24], p[23], p[22], |p[21:0]};
      ex   = e + 1;
    end else begin
      r.n  = 46 - msb;
      q    = p << r.n;
      r.mn = {q[45:23], q[22], q[21], |q[20:0]};
      ex   = e - r.n;
    end
    r.ex    = 10'(ex);
    r.ovf   = (ex > 127);
    r.uflow = !r.zero && (ex < -126);
    return r;
  endfunction

  // Runs one transaction from a point 1 time unit after a rising edge.
  task automatic do_txn(input logic [47:0] p, input int e, input logic s, input int hold,
                        input int stall_m);
    exp_t              m;
    int                cyc;
    int                waited;
    logic [63:0]       junk;
    logic signed [9:0] frz;
    m = model(p, e);
    bus.prod     = p;
    bus.exp_in   = 10'(e);
    bus.sign_in  = s;
    bus.in_valid = 1'b1;
    waited = 0;
    while (!bus.in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    // Junk keeps in_valid high while busy. The block must ignore it.
    junk         = {$urandom(), $urandom()};
    bus.prod     = junk[47:0];
    bus.exp_in   = junk[57:48];
    bus.sign_in  = ~s;
    cyc = 1;
    if (stall_m > 0) begin
      repeat (stall_m) begin
        @(posedge clk); #1;
        cyc++;
      end
      en = 1'b0;
      repeat (3) begin
        @(posedge clk); #1;
        cyc++;
      end
      frz = 10'(e - stall_m);
      check("freeze_exp", 64'(bus.exp_out), 64'(frz));
      check("freeze_valid", 64'(bus.out_valid), 64'd0);
      en = 1'b1;
    end
    while (!bus.out_valid && cyc <= 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 64'(cyc), 64'(1 + m.n + ((stall_m > 0) ? 3 : 0)));
    check("mul_normalize", 64'(bus.mul_normalize), 64'(m.mn));
    check("exp_out", 64'(bus.exp_out), 64'(m.ex));
    check("sign_out", 64'(bus.sign_out), 64'(s));
    check("zero_out", 64'(bus.zero_out), 64'(m.zero));
    check("ovf_out", 64'(bus.ovf_out), 64'(m.ovf));
    check("uflow_out", 64'(bus.uflow_out), 64'(m.uflow));
    check("busy_in_ready", 64'(bus.in_ready), 64'd0);
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_mn", 64'(bus.mul_normalize), 64'(m.mn));
      check("hold_exp", 64'(bus.exp_out), 64'(m.ex));
    end
    bus.out_ready = 1'b1;
    check("xfer_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("post_valid", 64'(bus.out_valid), 64'd0);
    check("post_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    logic [23:0] a;
    logic [23:0] b;
    logic [47:0] p;
    int          e;
    int          stall;
    exp_t        m;

    arst_n        = 1'b0;
    en            = 1'b1;
    bus.in_valid  = 1'b0;
    bus.prod      = '0;
    bus.exp_in    = '0;
    bus.sign_in   = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mn", 64'(bus.mul_normalize), 64'd0);
    check("rst_exp", 64'(bus.exp_out), 64'd0);
    check("rst_flags", 64'({bus.zero_out, bus.ovf_out, bus.uflow_out, bus.sign_out}), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    arst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corners
    do_txn(48'h4000_0000_0000, 0, 1'b0, 0, 0);
    do_txn(48'h8000_0000_0001, 5, 1'b0, 0, 0);
    do_txn(48'h0000_0000_0001, 0, 1'b0, 0, 0);
    do_txn(48'h0000_0000_0001, -100, 1'b1, 0, 0);
    do_txn(48'h0, 0, 1'b1, 0, 0);
    do_txn(48'hC000_0000_0000, 127, 1'b0, 0, 0);
    do_txn(48'h4000_0000_0000, -126, 1'b0, 0, 0);
    do_txn(48'h0000_0080_0003, 10, 1'b0, 5, 0);
    do_txn(48'h0000_0000_0001, 0, 1'b0, 0, 20);

    // Asynchronous reset in the middle of a shift sequence
    bus.prod     = 48'h0000_0000_0001;
    bus.exp_in   = 10'sd0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    arst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_exp", 64'(bus.exp_out), 64'd0);
    #2;
    arst_n = 1'b1;
    @(posedge clk); #1;
    do_txn(48'h0000_1234_5678, 3, 1'b1, 1, 0);

    // Random products of possibly denormal mantissas
    for (int t = 0; t < 40; t++) begin
      a = {1'b1, 23'($urandom())} >> $urandom_range(23);
      b = {1'b1, 23'($urandom())} >> $urandom_range(23);
      if ($urandom_range(9) == 0) a = '0;
      p = 48'(a) * 48'(b);
      e = int'($urandom_range(600)) - 300;
      m = model(p, e);
      stall = 0;
      if (m.n > 2 && $urandom_range(1) == 1) stall = int'($urandom_range(m.n - 1, 1));
      do_txn(p, e, 1'($urandom_range(1)), int'($urandom_range(3)), stall);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
